// File: rtl/matrix_store_ctrl.sv
// matrix_store_ctrl: captures matrices from the generator and UART input paths,
// arbitrates round-robin and streams them element-by-element into the matrix RAM,
// maintaining a per-size slot table with oldest-overwrite.
module matrix_store_ctrl #(
    parameter int SLOTS = 2,
    parameter int ELEMS = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         gen_valid,
    input  logic [2:0]   gen_m,
    input  logic [2:0]   gen_n,
    input  logic [199:0] gen_matrix_flat,
    input  logic         inp_valid,
    input  logic [2:0]   inp_m,
    input  logic [2:0]   inp_n,
    input  logic [199:0] inp_matrix_flat,
    input  logic         clr_all,
    output logic         gen_busy,
    output logic         inp_busy,
    output logic         wr_en,
    output logic [10:0]  wr_addr,
    output logic [7:0]   wr_data,
    output logic         store_done,
    output logic         store_src,
    output logic [5:0]   store_slot,
    output logic [49:0]  size_cnt_flat,
    output logic         err_dim,
    output logic         err_ovr
);

    typedef enum logic [1:0] {IDLE, WRITE, COMMIT} state_t;

    state_t state, state_next;

    // capture buffers
    logic         gen_full, inp_full;
    logic [2:0]   gen_bm, gen_bn, inp_bm, inp_bn;
    logic [199:0] gen_bflat, inp_bflat;
    logic         last_grant;   // 0 = gen, 1 = inp

    // working registers of the matrix being written
    logic         cur_src;
    logic [4:0]   cur_cls;
    logic [5:0]   cur_slot;
    logic [10:0]  cur_base;
    logic [4:0]   cur_total;
    logic [199:0] cur_flat;
    logic [4:0]   k;

    // slot table
    logic [1:0]   cnt [25];
    logic [24:0]  ptr;

    logic         grant_gen, grant_inp;
    logic [2:0]   sel_m, sel_n;
    logic [199:0] sel_flat;
    logic [4:0]   sel_cls;
    logic [5:0]   sel_slot;
    logic [10:0]  sel_base;
    logic [4:0]   sel_total;
    logic         gen_ok, inp_ok;
    logic         gen_load, inp_load;

    function automatic logic dims_ok(input logic [2:0] m, input logic [2:0] n);
        return (m != 3'd0) && (m <= 3'd5) && (n != 3'd0) && (n <= 3'd5);
    endfunction

    assign gen_busy = gen_full;
    assign inp_busy = inp_full;

    // Next-state logic with round-robin arbitration in IDLE.
    // k runs one ahead of the element on the bus (element 0 is issued at grant),
    // so the last element has been issued once k reaches m*n.
    always_comb begin
        state_next = state;
        grant_gen  = 1'b0;
        grant_inp  = 1'b0;
        case (state)
            IDLE: begin
                if (gen_full && (!inp_full || last_grant)) begin
                    grant_gen  = 1'b1;
                    state_next = WRITE;
                end else if (inp_full) begin
                    grant_inp  = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (k == cur_total) state_next = COMMIT;
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Granted-buffer selection and slot/address computation.
    always_comb begin
        sel_m     = grant_inp ? inp_bm : gen_bm;
        sel_n     = grant_inp ? inp_bn : gen_bn;
        sel_flat  = grant_inp ? inp_bflat : gen_bflat;
        sel_cls   = 5'((int'(sel_m) - 1) * 5 + int'(sel_n) - 1);
        sel_slot  = 6'(int'(sel_cls) * SLOTS + int'(ptr[sel_cls]));
        sel_base  = 11'(int'(sel_slot) * ELEMS);
        sel_total = 5'(int'(sel_m) * int'(sel_n));
    end

    // Capture qualification; a buffer being granted this cycle counts as free.
    always_comb begin
        gen_ok   = dims_ok(gen_m, gen_n);
        inp_ok   = dims_ok(inp_m, inp_n);
        gen_load = gen_valid && gen_ok && (!gen_full || grant_gen);
        inp_load = inp_valid && inp_ok && (!inp_full || grant_inp);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Capture buffers, error pulses and last-grant tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_full   <= 1'b0;
            inp_full   <= 1'b0;
            gen_bm     <= '0;
            gen_bn     <= '0;
            gen_bflat  <= '0;
            inp_bm     <= '0;
            inp_bn     <= '0;
            inp_bflat  <= '0;
            last_grant <= 1'b1;
            err_dim    <= 1'b0;
            err_ovr    <= 1'b0;
        end else begin
            if (gen_load) begin
                gen_full  <= 1'b1;
                gen_bm    <= gen_m;
                gen_bn    <= gen_n;
                gen_bflat <= gen_matrix_flat;
            end else if (grant_gen) begin
                gen_full  <= 1'b0;
            end
            if (inp_load) begin
                inp_full  <= 1'b1;
                inp_bm    <= inp_m;
                inp_bn    <= inp_n;
                inp_bflat <= inp_matrix_flat;
            end else if (grant_inp) begin
                inp_full  <= 1'b0;
            end
            if (grant_gen)      last_grant <= 1'b0;
            else if (grant_inp) last_grant <= 1'b1;
            err_dim <= (gen_valid && !gen_ok) || (inp_valid && !inp_ok);
            err_ovr <= (gen_valid && gen_ok && gen_full && !grant_gen) ||
                       (inp_valid && inp_ok && inp_full && !grant_inp);
        end
    end

    // Write engine: latches the granted matrix and streams one element per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_src    <= 1'b0;
            cur_cls    <= '0;
            cur_slot   <= '0;
            cur_base   <= '0;
            cur_total  <= '0;
            cur_flat   <= '0;
            k          <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            store_done <= 1'b0;
            store_src  <= 1'b0;
            store_slot <= '0;
        end else begin
            store_done <= 1'b0;
            if (grant_gen || grant_inp) begin
                cur_src   <= grant_inp;
                cur_cls   <= sel_cls;
                cur_slot  <= sel_slot;
                cur_base  <= sel_base;
                cur_total <= sel_total;
                cur_flat  <= sel_flat;
                k         <= 5'd1;
                wr_en     <= 1'b1;
                wr_addr   <= sel_base;
                wr_data   <= sel_flat[7:0];
            end else if (state == WRITE) begin
                if (k == cur_total) begin
                    wr_en      <= 1'b0;
                    store_done <= 1'b1;
                    store_src  <= cur_src;
                    store_slot <= cur_slot;
                end else begin
                    wr_en   <= 1'b1;
                    wr_addr <= cur_base + 11'(k);
                    wr_data <= cur_flat[{k, 3'b000} +: 8];
                    k       <= k + 5'd1;
                end
            end
        end
    end

    // Slot table; the committing class overrides a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '{default: '0};
            ptr <= '0;
        end else begin
            if (clr_all) begin
                cnt <= '{default: '0};
                ptr <= '0;
            end
            if (state == COMMIT) begin
                ptr[cur_cls] <= ~ptr[cur_cls];
                if (clr_all)
                    cnt[cur_cls] <= 2'd1;
                else if (cnt[cur_cls] != 2'(SLOTS))
                    cnt[cur_cls] <= cnt[cur_cls] + 2'd1;
            end
        end
    end

    for (genvar c = 0; c < 25; c++) begin : g_cnt_flat
        assign size_cnt_flat[2*c +: 2] = cnt[c];
    end

endmodule

// File: tb/tb_matrix_store_ctrl.sv
// Testbench for matrix_store_ctrl: directed stimulus with hand-computed slots;
// expected RAM writes and commits go to queues checked by a negedge monitor.
module tb_matrix_store_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         gen_valid = 1'b0;
    logic [2:0]   gen_m = '0, gen_n = '0;
    logic [199:0] gen_matrix_flat = '0;
    logic         inp_valid = 1'b0;
    logic [2:0]   inp_m = '0, inp_n = '0;
    logic [199:0] inp_matrix_flat = '0;
    logic         clr_all = 1'b0;
    logic         gen_busy, inp_busy, wr_en, store_done, store_src, err_dim, err_ovr;
    logic [10:0]  wr_addr;
    logic [7:0]   wr_data;
    logic [5:0]   store_slot;
    logic [49:0]  size_cnt_flat;

    matrix_store_ctrl #(.SLOTS(2), .ELEMS(25)) dut (
        .clk(clk), .rst_n(rst_n),
        .gen_valid(gen_valid), .gen_m(gen_m), .gen_n(gen_n), .gen_matrix_flat(gen_matrix_flat),
        .inp_valid(inp_valid), .inp_m(inp_m), .inp_n(inp_n), .inp_matrix_flat(inp_matrix_flat),
        .clr_all(clr_all), .gen_busy(gen_busy), .inp_busy(inp_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .store_done(store_done), .store_src(store_src), .store_slot(store_slot),
        .size_cnt_flat(size_cnt_flat), .err_dim(err_dim), .err_ovr(err_ovr)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [10:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic src; logic [5:0] slot; } cm_t;

    wr_t wq[$];
    cm_t cq[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] cntv(input int cls, input int v);
        return 64'(v) << (2 * cls);
    endfunction

    function automatic logic [199:0] mk_flat(input int num, input int base);
        logic [199:0] f = '0;
        for (int i = 0; i < num && i < 25; i++) f[i*8 +: 8] = 8'(base + i);
        return f;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_exp(input bit src, input int m, input int n, input int base, input int slot);
        for (int i = 0; i < m * n; i++) wq.push_back('{addr: 11'(slot * 25 + i), data: 8'(base + i)});
        cq.push_back('{src: src, slot: 6'(slot)});
    endtask

    // Valid high for one cycle (T); returns #1 into cycle T+1.
    task automatic pulse(input bit gv, input int gm, input int gn, input int gb,
                         input bit iv, input int im, input int in_n, input int ib);
        @(posedge clk); #1;
        gen_valid = gv; gen_m = 3'(gm); gen_n = 3'(gn); gen_matrix_flat = mk_flat(gm * gn, gb);
        inp_valid = iv; inp_m = 3'(im); inp_n = 3'(in_n); inp_matrix_flat = mk_flat(im * in_n, ib);
        @(posedge clk); #1;
        gen_valid = 1'b0;
        inp_valid = 1'b0;
    endtask

    task automatic run_one(input bit src, input int m, input int n, input int base, input int slot);
        push_exp(src, m, n, base, slot);
        if (src) pulse(0, 0, 0, 0, 1, m, n, base);
        else     pulse(1, m, n, base, 0, 0, 0, 0);
        repeat (m * n + 2) step();
    endtask

    task automatic do_reset();
        gen_valid = 1'b0; inp_valid = 1'b0; clr_all = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: every write and commit the DUT presents must match the queue head.
    always @(negedge clk) begin : mon
        wr_t w;
        cm_t c;
        if (rst_n) begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0h expected none", wr_addr, wr_data);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(w.addr));
                    chk("wr_data", 64'(wr_data), 64'(w.data));
                end
            end
            if (store_done) begin
                if (cq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_commit: got slot=%0d src=%0d expected none", store_slot, store_src);
                end else begin
                    c = cq.pop_front();
                    chk("store_src", 64'(store_src), 64'(c.src));
                    chk("store_slot", 64'(store_slot), 64'(c.slot));
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (2) step();
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_cnt", 64'(size_cnt_flat), 64'd0);
        rst_n = 1'b1;
        step();
        chk("rst_done", 64'(store_done), 64'd0);
        chk("rst_busy", 64'({gen_busy, inp_busy}), 64'd0);
        chk("rst_err", 64'({err_dim, err_ovr}), 64'd0);
        chk("rst_addr", 64'(wr_addr), 64'd0);

        // gen 2x3, class 7 -> slot 14, addresses 350..355, exact latency
        push_exp(0, 2, 3, 1, 14);
        pulse(1, 2, 3, 1, 0, 0, 0, 0);                // now T+1
        chk("lat_busy_t1", 64'(gen_busy), 64'd1);
        chk("lat_wren_t1", 64'(wr_en), 64'd0);
        step();                                       // T+2
        chk("lat_busy_t2", 64'(gen_busy), 64'd0);
        chk("lat_wren_t2", 64'(wr_en), 64'd1);
        chk("lat_addr_t2", 64'(wr_addr), 64'd350);
        repeat (5) step();                            // T+7
        chk("lat_wren_t7", 64'(wr_en), 64'd1);
        step();                                       // T+8
        chk("lat_done_t8", 64'(store_done), 64'd1);
        chk("lat_wren_t8", 64'(wr_en), 64'd0);
        step();                                       // T+9
        chk("lat_done_t9", 64'(store_done), 64'd0);
        chk("cnt7", 64'(size_cnt_flat), cntv(7, 1));

        // three gen 1x1 -> slots 0,1,0 with saturation
        do_reset();
        run_one(0, 1, 1, 8'h11, 0);
        chk("cnt0_a", 64'(size_cnt_flat), cntv(0, 1));
        run_one(0, 1, 1, 8'h22, 1);
        chk("cnt0_b", 64'(size_cnt_flat), cntv(0, 2));
        run_one(0, 1, 1, 8'h33, 0);
        chk("cnt0_sat", 64'(size_cnt_flat), cntv(0, 2));

        // simultaneous 3x3 from both ports: gen first (class 12 -> slots 24, 25)
        do_reset();
        push_exp(0, 3, 3, 8'h10, 24);
        push_exp(1, 3, 3, 8'h40, 25);
        pulse(1, 3, 3, 8'h10, 1, 3, 3, 8'h40);
        repeat (24) step();
        push_exp(0, 3, 3, 8'h50, 24);
        push_exp(1, 3, 3, 8'h60, 25);
        pulse(1, 3, 3, 8'h50, 1, 3, 3, 8'h60);
        repeat (24) step();
        chk("cnt12", 64'(size_cnt_flat), cntv(12, 2));
        // gen granted last -> inp wins the next tie
        run_one(0, 1, 1, 8'h70, 0);
        push_exp(1, 1, 1, 8'h80, 1);
        push_exp(0, 1, 1, 8'h90, 0);
        pulse(1, 1, 1, 8'h90, 1, 1, 1, 8'h80);
        repeat (10) step();
        chk("cnt_rr", 64'(size_cnt_flat), cntv(12, 2) | cntv(0, 2));

        // overflow: third back-to-back gen pulse finds the buffer full
        do_reset();
        push_exp(0, 1, 1, 8'hA0, 0);
        push_exp(0, 1, 1, 8'hB0, 1);
        @(posedge clk); #1;                           // T
        gen_valid = 1'b1; gen_m = 3'd1; gen_n = 3'd1; gen_matrix_flat = mk_flat(1, 8'hA0);
        step();                                       // T+1
        gen_matrix_flat = mk_flat(1, 8'hB0);
        step();                                       // T+2
        chk("ovr_busy", 64'(gen_busy), 64'd1);
        gen_matrix_flat = mk_flat(1, 8'hC0);
        step();                                       // T+3
        gen_valid = 1'b0;
        chk("ovr_pulse", 64'(err_ovr), 64'd1);
        chk("ovr_nodim", 64'(err_dim), 64'd0);
        step();                                       // T+4
        chk("ovr_width", 64'(err_ovr), 64'd0);
        repeat (3) step();                            // T+7
        chk("ovr_cnt", 64'(size_cnt_flat), cntv(0, 2));

        // invalid dimensions on both ports in the same cycle, then 5x6 alone
        pulse(1, 0, 1, 8'h01, 1, 6, 2, 8'h02);
        chk("dim_both", 64'(err_dim), 64'd1);
        chk("dim_noovr", 64'(err_ovr), 64'd0);
        chk("dim_nobusy", 64'({gen_busy, inp_busy}), 64'd0);
        step();
        chk("dim_width", 64'(err_dim), 64'd0);
        pulse(1, 5, 6, 8'h03, 0, 0, 0, 0);
        chk("dim_n6", 64'(err_dim), 64'd1);
        repeat (4) step();

        // clr_all during a 4x4 write (class 18)
        do_reset();
        run_one(0, 4, 4, 8'h01, 36);
        run_one(1, 4, 4, 8'h21, 37);
        run_one(0, 1, 1, 8'h55, 0);
        chk("clr_pre", 64'(size_cnt_flat), cntv(18, 2) | cntv(0, 1));
        push_exp(0, 4, 4, 8'h31, 36);
        pulse(1, 4, 4, 8'h31, 0, 0, 0, 0);
        repeat (5) step();
        clr_all = 1'b1;
        step();
        clr_all = 1'b0;
        chk("clr_mid", 64'(size_cnt_flat), 64'd0);
        repeat (13) step();
        chk("clr_post", 64'(size_cnt_flat), cntv(18, 1));
        run_one(0, 4, 4, 8'h61, 37);
        chk("clr_ptr", 64'(size_cnt_flat), cntv(18, 2));
        // clr_all coinciding with COMMIT of class 0
        push_exp(0, 1, 1, 8'h77, 0);
        pulse(1, 1, 1, 8'h77, 0, 0, 0, 0);
        repeat (2) step();                            // T+3 (COMMIT)
        chk("clrc_done", 64'(store_done), 64'd1);
        clr_all = 1'b1;
        step();
        clr_all = 1'b0;
        chk("clrc_cnt", 64'(size_cnt_flat), cntv(0, 1));
        run_one(0, 1, 1, 8'h78, 1);
        chk("clrc_ptr", 64'(size_cnt_flat), cntv(0, 2));

        // 5x5 at the top of the address range, then reset mid-write
        do_reset();
        run_one(1, 5, 5, 8'h00, 48);
        run_one(1, 5, 5, 8'h80, 49);
        chk("cnt24", 64'(size_cnt_flat), cntv(24, 2));
        wq.push_back('{addr: 11'd1200, data: 8'hE0});
        wq.push_back('{addr: 11'd1201, data: 8'hE1});
        pulse(1, 5, 5, 8'hE0, 0, 0, 0, 0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("arst_wren", 64'(wr_en), 64'd0);
        chk("arst_cnt", 64'(size_cnt_flat), 64'd0);
        chk("arst_busy", 64'(gen_busy), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (35) step();

        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("cq_empty", 64'(cq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
